// File: rtl/shift_tx_ctrl_if.sv
// Handshake bundle for shift_tx_ctrl.
//   tx_*      : word handshake from the upstream source (valid/ready)
//   bit_*     : serial bit handshake to the downstream consumer (valid/ready)
// master = source/consumer side, slave = the serializer controller.
interface shift_tx_ctrl_if;
  logic       tx_valid;
  logic [3:0] tx_data;
  logic       tx_dir;
  logic       tx_fill;
  logic       tx_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;

  modport master (
    output tx_valid, tx_data, tx_dir, tx_fill, bit_ready,
    input  tx_ready, bit_out, bit_valid
  );

  modport slave (
    input  tx_valid, tx_data, tx_dir, tx_fill, bit_ready,
    output tx_ready, bit_out, bit_valid
  );
endinterface

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: drives a 4-bit universal shift register to serialize words.
// A word is accepted in IDLE, parallel-loaded into the register (LOAD),
// shifted out one bit per bit_ready handshake (SHIFT x4), then DONE pulses.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset (shared with register)
//   tx          : slave modport - word handshake in, serial bit handshake out
//   A           : current register contents
//   S           : register mode (00 hold, 01 right, 10 left, 11 load)
//   I           : parallel-load value (captured word)
//   MSB_in/LSB_in : serial fill inputs to the register
//   done        : one-cycle pulse after the 4th bit is taken
module shift_tx_ctrl (
  input  logic             clk,
  input  logic             rstn,
  shift_tx_ctrl_if.slave   tx,
  input  logic [3:0]       A,
  output logic [1:0]       S,
  output logic [3:0]       I,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] word;
  logic       dir;
  logic       fill;
  logic       rdy_q;
  logic       bv_q;
  logic       done_q;

  // Status flags are registered alongside the state so they are pure flops;
  // each one is set on the transition into the state that asserts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      word   <= 4'd0;
      dir    <= 1'b0;
      fill   <= 1'b0;
      rdy_q  <= 1'b1;
      bv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tx.tx_valid) begin
          word  <= tx.tx_data;
          dir   <= tx.tx_dir;
          fill  <= tx.tx_fill;
          rdy_q <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          cnt   <= 2'd0;
          bv_q  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (tx.bit_ready) begin
          cnt <= cnt + 2'd1;              // wraps to 0 after the 4th bit
          if (cnt == 2'd3) begin
            bv_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          rdy_q  <= 1'b1;
          fill   <= 1'b0;                 // serial inputs read 0 while idle
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mode decode: only SHIFT looks at bit_ready; a stall holds the register.
  always_comb begin
    S = 2'b00;
    case (state)
      LOAD:    S = 2'b11;
      SHIFT:   if (tx.bit_ready) S = dir ? 2'b10 : 2'b01;
      default: S = 2'b00;
    endcase
  end

  // The bit on the outgoing end of the register is the current serial bit.
  assign tx.bit_out   = dir ? A[3] : A[0];
  assign tx.bit_valid = bv_q;
  assign tx.tx_ready  = rdy_q;
  assign done         = done_q;
  assign I            = word;
  assign MSB_in       = fill;
  assign LSB_in       = fill;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: models the downstream 4-bit universal shift
// register, drives directed and random words, and scores every cycle
// against a word-level reference (expected bit queue per accepted word).
module tb_shift_tx_ctrl;
  logic       clk;
  logic       rstn;
  logic [3:0] A;
  logic [1:0] S;
  logic [3:0] I;
  logic       MSB_in, LSB_in, done;

  shift_tx_ctrl_if u_if();

  shift_tx_ctrl u_dut (
    .clk    (clk),
    .rstn   (rstn),
    .tx     (u_if),
    .A      (A),
    .S      (S),
    .I      (I),
    .MSB_in (MSB_in),
    .LSB_in (LSB_in),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream universal shift register, reset by the same rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) A <= 4'd0;
    else case (S)
      2'b01: A <= {MSB_in, A[3:1]};
      2'b10: A <= {A[2:0], LSB_in};
      2'b11: A <= I;
      default: A <= A;
    endcase
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  // ph: 0 idle, 1 load, 2 shifting, 3 done
  int         ph = 0;
  int         taken = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         stalls = 0;
  logic [3:0] m_word;
  logic       m_dir, m_fill;
  logic       q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("rst_ready", u_if.tx_ready, 1);
      chk("rst_S", S, 0);
      chk("rst_bv", u_if.bit_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_I", I, 0);
      chk("rst_fill", {MSB_in, LSB_in}, 0);
      ph = 0;
      q.delete();
    end else begin
      case (ph)
        0: begin
          chk("idle_ready", u_if.tx_ready, 1);
          chk("idle_S", S, 0);
          chk("idle_bv", u_if.bit_valid, 0);
          chk("idle_done", done, 0);
          chk("idle_fill", {MSB_in, LSB_in}, 0);
          if (u_if.tx_valid) begin
            m_word = u_if.tx_data; m_dir = u_if.tx_dir; m_fill = u_if.tx_fill;
            q.delete();
            for (int i = 0; i < 4; i++) q.push_back(m_dir ? m_word[3-i] : m_word[i]);
            taken = 0; stalls = 0; acc_cyc = cyc; ph = 1;
          end
        end
        1: begin
          chk("load_S", S, 3);
          chk("load_I", I, m_word);
          chk("load_ready", u_if.tx_ready, 0);
          chk("load_bv", u_if.bit_valid, 0);
          chk("load_fill", {MSB_in, LSB_in}, {m_fill, m_fill});
          ph = 2;
        end
        2: begin
          chk("sh_bv", u_if.bit_valid, 1);
          chk("sh_ready", u_if.tx_ready, 0);
          chk("sh_done", done, 0);
          chk("sh_fill", {MSB_in, LSB_in}, {m_fill, m_fill});
          chk("sh_I", I, m_word);
          chk("sh_bit", u_if.bit_out, q[0]);
          if (u_if.bit_ready) begin
            chk("sh_S", S, m_dir ? 2 : 1);
            void'(q.pop_front());
            taken++;
            if (q.size() == 0) ph = 3;
          end else begin
            chk("stall_S", S, 0);
            stalls++;
          end
        end
        default: begin
          chk("done_pulse", done, 1);
          chk("done_S", S, 0);
          chk("done_bv", u_if.bit_valid, 0);
          chk("done_ready", u_if.tx_ready, 0);
          chk("done_A", A, {4{m_fill}});
          chk("done_lat", cyc - acc_cyc, 6 + stalls);
          ph = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  // Offer a word, then run it to completion (or abort with reset once
  // abort_at bits have been taken). tx_data is scrambled while busy.
  task automatic send_word(input logic [3:0] d, input logic dr, input logic fl,
                           input int stall_at, input int stall_len, input bit rnd,
                           input bit hold, input int abort_at);
    bit acc = 0;
    bit stalled = 0;
    bit fin = 0;
    int scnt = 0;
    u_if.tx_data = d; u_if.tx_dir = dr; u_if.tx_fill = fl; u_if.tx_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = u_if.tx_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    u_if.tx_valid = hold;
    for (int n = 0; n < 200 && !fin; n++) begin
      u_if.tx_data = 4'($urandom);
      u_if.tx_dir  = 1'($urandom);
      u_if.tx_fill = 1'($urandom);
      if (ph == 0) fin = 1;
      else if (abort_at >= 0 && taken == abort_at) begin
        rstn = 1'b0;
        u_if.tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        fin = 1;
      end else begin
        if (scnt > 0) begin
          u_if.bit_ready = 1'b0; scnt--;
        end else if (!stalled && stall_at >= 0 && taken == stall_at && ph == 2) begin
          stalled = 1; scnt = stall_len - 1; u_if.bit_ready = 1'b0;
        end else
          u_if.bit_ready = rnd ? 1'($urandom) : 1'b1;
        @(posedge clk); #1;
      end
    end
    if (!fin) chk("word_timeout", 0, 1);
  endtask

  initial begin
    rstn = 1'b0;
    u_if.tx_valid = 1'b0; u_if.tx_data = 4'd0; u_if.tx_dir = 1'b0;
    u_if.tx_fill = 1'b0; u_if.bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // LSB first, fill 0; then MSB first, fill 1
    send_word(4'b1010, 1'b0, 1'b0, -1, 0, 0, 0, -1);
    send_word(4'b1010, 1'b1, 1'b1, -1, 0, 0, 0, -1);
    // 3-cycle stall after the 2nd bit
    send_word(4'b0110, 1'b0, 1'b0, 2, 3, 0, 0, -1);
    // back-to-back with tx_valid held high
    for (int k = 0; k < 4; k++)
      send_word(k[0] ? 4'b1100 : 4'b0011, k[1], k[0], -1, 0, 0, 1, -1);
    // reset during the 3rd SHIFT cycle, then a clean word
    u_if.tx_valid = 1'b0;
    send_word(4'b1011, 1'b0, 1'b1, -1, 0, 0, 0, 2);
    send_word(4'b1001, 1'b1, 1'b0, -1, 0, 0, 0, -1);
    // random words with random backpressure
    for (int k = 0; k < 30; k++)
      send_word(4'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 5)),
                1, 1'($urandom), -1);
    u_if.tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
